// File: rtl/frame_scanout_pkg.sv
// Shared constants, FSM encoding and CRC helper for the frame scan-out block.
// Used by frame_scanout and scan_fifo.
package frame_scanout_pkg;

    localparam int PIX_CODE_W = 3;
    localparam int H_PIX_DEF  = 640;
    localparam int V_PIX_DEF  = 480;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One MSB-first step of CRC-16/CCITT.
    function automatic logic [15:0] crc16_bit(
        input logic [15:0] c,
        input logic        b
    );
        logic fb;
        fb = c[15] ^ b;
        crc16_bit = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/scan_fifo.sv
// Synchronous FIFO holding pixel plus SOF/EOL/EOF tags.
// Head entry is visible on o_rdata the cycle after it is written.
module scan_fifo
    import frame_scanout_pkg::*;
#(
    parameter int W     = 6,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_wr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_rd,
    output logic [W-1:0]  o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_wr;
    logic          w_rd;

    assign w_wr    = i_wr && (r_cnt != CW'(DEPTH));
    assign w_rd    = i_rd && (r_cnt != '0);
    assign o_rdata = r_mem[r_rp];
    assign o_count = r_cnt;
    assign o_empty = (r_cnt == '0);

    // Storage array, no reset needed: entries are qualified by the count.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= i_wdata;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            if (w_rd) r_rp <= (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/frame_scanout.sv
// Raster-order frame scan-out: issues pixel reads, absorbs memory latency,
// emits a tagged valid/ready pixel stream. Optional CRC with FRAME_CRC_EN.
module frame_scanout
    import frame_scanout_pkg::*;
#(
    parameter int H_PIX      = H_PIX_DEF,
    parameter int V_PIX      = V_PIX_DEF,
    parameter int PIX_W      = PIX_CODE_W,
    parameter int ADDR_W     = 19,
    parameter int MEM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              frame_req,
    input  logic              cont,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [PIX_W-1:0]  mem_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       crc_out,
    output logic              crc_valid
);

    localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int YW = (V_PIX > 1) ? $clog2(V_PIX) : 1;
    localparam int TW = PIX_W + 3;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int LW = $clog2(MEM_LAT + 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_consume;
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_pend;
    logic [LW-1:0]     r_infl;
    logic [MEM_LAT-1:0] r_vp;
    logic [2:0]        r_tp [MEM_LAT];
    logic [15:0]       r_frame_cnt;

    logic              w_last_x;
    logic              w_last_y;
    logic [2:0]        w_tag;
    logic              w_issue;
    logic              w_ret;
    int                w_used;
    logic [TW-1:0]     w_head;
    logic [CW-1:0]     w_fcnt;
    logic              w_empty;
    logic              w_pop;
    logic              w_eof_xfer;

    assign w_last_x = (r_x == XW'(H_PIX - 1));
    assign w_last_y = (r_y == YW'(V_PIX - 1));
    assign w_tag    = {(r_x == '0) && (r_y == '0), w_last_x, w_last_x && w_last_y};
    assign w_ret    = r_vp[MEM_LAT-1];

    assign pix_valid  = !w_empty;
    assign w_pop      = pix_valid && pix_ready;
    assign w_eof_xfer = w_pop && w_head[TW-3];

    // Reads in flight plus buffered beats never exceed the buffer size.
    assign w_used  = int'(r_infl) + int'(w_fcnt) - int'(w_pop);
    assign w_issue = (r_state == ST_RUN) && (w_used < FIFO_DEPTH);

    assign mem_rd    = w_issue;
    assign mem_addr  = r_addr;
    assign pix_data  = pix_valid ? w_head[PIX_W-1:0] : '0;
    assign pix_sof   = pix_valid && w_head[TW-1];
    assign pix_eol   = pix_valid && w_head[TW-2];
    assign pix_eof   = pix_valid && w_head[TW-3];
    assign busy      = (r_state != ST_IDLE);
    assign frame_cnt = r_frame_cnt;

    scan_fifo #(
        .W     (TW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clr     (clr),
        .i_wr    (w_ret),
        .i_wdata ({r_tp[MEM_LAT-1], mem_data}),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_count (w_fcnt),
        .o_empty (w_empty)
    );

    // Next-state logic; w_consume marks entry into RUN.
    always_comb begin
        w_next    = r_state;
        w_consume = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (frame_req || r_pend || cont) begin
                    w_next    = ST_RUN;
                    w_consume = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_issue && w_last_x && w_last_y) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_eof_xfer) begin
                    if (cont || r_pend || frame_req) begin
                        w_next    = ST_RUN;
                        w_consume = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, pending request and frame counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_IDLE;
            r_pend      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_consume)            r_pend <= 1'b0;
            else if (frame_req && busy) r_pend <= 1'b1;
            if (w_eof_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Raster counters advance once per issued read.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (w_issue) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
            r_addr <= (w_last_x && w_last_y) ? '0 : r_addr + ADDR_W'(1);
        end
    end

    // Tag pipe matching the memory latency, plus in-flight read count.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_vp   <= '0;
            r_infl <= '0;
            for (int i = 0; i < MEM_LAT; i++) r_tp[i] <= '0;
        end else begin
            r_vp[0] <= w_issue;
            r_tp[0] <= w_tag;
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                r_vp[i] <= r_vp[i-1];
                r_tp[i] <= r_tp[i-1];
            end
            unique case ({w_issue, w_ret})
                2'b10:   r_infl <= r_infl + LW'(1);
                2'b01:   r_infl <= r_infl - LW'(1);
                default: r_infl <= r_infl;
            endcase
        end
    end

`ifdef FRAME_CRC_EN
    logic [15:0] r_crc_acc;
    logic [15:0] r_crc_out;
    logic        r_crc_vld;
    logic [15:0] w_crc_nxt;

    // CRC over the transferring beat, restarted on SOF.
    always_comb begin
        w_crc_nxt = w_head[TW-1] ? CRC_INIT : r_crc_acc;
        for (int i = PIX_W - 1; i >= 0; i--) begin
            w_crc_nxt = crc16_bit(w_crc_nxt, w_head[i]);
        end
    end

    // Accumulate per beat; publish the final value after EOF.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_crc_acc <= CRC_INIT;
            r_crc_out <= '0;
            r_crc_vld <= 1'b0;
        end else begin
            r_crc_vld <= w_eof_xfer;
            if (w_pop)      r_crc_acc <= w_crc_nxt;
            if (w_eof_xfer) r_crc_out <= w_crc_nxt;
        end
    end

    assign crc_out   = r_crc_out;
    assign crc_valid = r_crc_vld;
`else
    assign crc_out   = '0;
    assign crc_valid = 1'b0;
`endif

endmodule
